// File: rtl/jtag_byte_shifter.sv
// Serialises upstream fifo words LSB-first onto TDI under a generated TCK and, when
// JTAG_SHIFTER_CAPTURE_EN is defined, captures TDO into a word pushed downstream.
module jtag_byte_shifter #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_empty,
    output logic                  in_rd,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_wr,
    input  logic                  out_full,
    output logic                  tck,
    output logic                  tdi,
    input  logic                  tdo,
    output logic                  busy
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI
`ifdef JTAG_SHIFTER_CAPTURE_EN
        , STORE
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  tck_q, tck_d;
    logic                  tdi_q, tdi_d;
`ifdef JTAG_SHIFTER_CAPTURE_EN
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        tck_d     = tck_q;
        tdi_d     = tdi_q;
        in_rd     = 1'b0;
        out_wr    = 1'b0;
`ifdef JTAG_SHIFTER_CAPTURE_EN
        cap_d      = cap_q;
        out_data_d = out_data_q;
`endif
        case (state_q)
            IDLE: begin
                tck_d = 1'b0;
                if (en && !in_empty) begin
                    in_rd     = 1'b1;
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    tdi_d     = in_data[0];
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    tck_d     = 1'b1;
`ifdef JTAG_SHIFTER_CAPTURE_EN
                    // TDO is taken on the same edge that raises TCK
                    cap_d[bit_cnt_q] = tdo;
`endif
                    state_d   = SHIFT_HI;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    tck_d     = 1'b0;
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef JTAG_SHIFTER_CAPTURE_EN
                        out_data_d = cap_q;
                        state_d    = STORE;
`else
                        state_d    = IDLE;
`endif
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        tdi_d     = shreg_q[1];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        state_d   = SHIFT_LO;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
`ifdef JTAG_SHIFTER_CAPTURE_EN
            STORE: begin
                tck_d = 1'b0;
                if (!out_full) begin
                    out_wr  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            tck_q     <= 1'b0;
            tdi_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            tck_q     <= tck_d;
            tdi_q     <= tdi_d;
        end
    end

`ifdef JTAG_SHIFTER_CAPTURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q      <= '0;
            out_data_q <= '0;
        end else begin
            cap_q      <= cap_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;

    logic unused_bits;
    assign unused_bits = shreg_q[0];
`else
    assign out_data = '0;

    // Without capture the downstream side and TDO have no effect
    logic unused_bits;
    assign unused_bits = ^{shreg_q[0], out_full, tdo};
`endif

    assign tck  = tck_q;
    assign tdi  = tdi_q;
    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_jtag_byte_shifter.sv
// Scoreboarded bench: fifo model feeds words, a monitor rebuilds TDI words and timing from pins.
module tb_jtag_byte_shifter;
    localparam int DW = 8;
    localparam int CD = 2;
`ifdef JTAG_SHIFTER_CAPTURE_EN
    localparam int CAP = 1;
`else
    localparam int CAP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_empty = 1'b1;
    logic          out_full = 1'b0;
    logic          in_rd, out_wr, tck, tdi, tdo, busy;
    logic [DW-1:0] out_data;

    jtag_byte_shifter #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_empty(in_empty),
        .in_rd(in_rd), .out_data(out_data), .out_wr(out_wr), .out_full(out_full),
        .tck(tck), .tdi(tdi), .tdo(tdo), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // upstream fifo model, per-word TDO flip masks, and expectations
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] mask_q[$];
    logic [DW-1:0] exp_tdi_q[$];
    logic [DW-1:0] exp_out_q[$];
    logic [DW-1:0] cur_mask = '0;
    logic [DW-1:0] cur_bits = '0;
    int mon_bits = 0;
    int rd_cnt = 0, rise_cnt = 0, words_done = 0;
    logic pend = 1'b0;

    // target model: returns TDI, optionally inverted per bit by the word's mask
    assign tdo = tdi ^ cur_mask[mon_bits];

    task automatic refresh();
        in_empty = (fifo_q.size() == 0);
        in_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] w, input logic [DW-1:0] m);
        fifo_q.push_back(w);
        mask_q.push_back(m);
        refresh();
    endtask

    always begin
        logic [DW-1:0] w, m;
        @(negedge clk);
        pend = in_rd && !rst;
        if (pend) check("rd_not_empty", in_empty, 1'b0);
        @(posedge clk);
        #1;
        if (pend && fifo_q.size() != 0) begin
            w = fifo_q.pop_front();
            m = mask_q.pop_front();
            exp_tdi_q.push_back(w);
`ifdef JTAG_SHIFTER_CAPTURE_EN
            exp_out_q.push_back(w ^ m);
`endif
            cur_mask = m;
            rd_cnt++;
            refresh();
        end
        pend = 1'b0;
    end

    // pin monitor
    logic prev_tck = 1'b0, rise_tdi = 1'b0, bp = 1'b0;
    int run_len = 0, hi_len = 0, since_rise = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_tck = 1'b0; mon_bits = 0; run_len = 0; bp = 1'b0; hi_len = 0; since_rise = 0;
        end else begin
            check("in_rd_rule", in_rd, !busy && en && !in_empty);
            if (!busy) check("tck_idle", tck, 1'b0);
`ifdef JTAG_SHIFTER_CAPTURE_EN
            if (out_full) check("out_wr_full", out_wr, 1'b0);
`else
            check("out_wr_off", out_wr, 1'b0);
            check("out_data_off", out_data, 0);
`endif
            if (busy) begin
                run_len++;
                if (out_full) bp = 1'b1;
            end else if (run_len > 0) begin
                if (!bp) check("word_cycles", run_len, 2 * CD * DW + CAP);
                run_len = 0;
                bp = 1'b0;
            end
            if (tck && !prev_tck) begin
                if (mon_bits > 0) check("tck_period", since_rise, 2 * CD);
                since_rise = 0;
                hi_len = 0;
                rise_tdi = tdi;
                cur_bits[mon_bits] = tdi;
                rise_cnt++;
            end
            if (tck) begin
                hi_len++;
                check("tdi_stable_hi", tdi, rise_tdi);
            end
            if (!tck && prev_tck) begin
                check("tck_high_len", hi_len, CD);
                if (mon_bits == DW - 1) begin
                    if (exp_tdi_q.size() == 0) check("tdi_word_unexpected", 1, 0);
                    else check("tdi_word", cur_bits, exp_tdi_q.pop_front());
                    mon_bits = 0;
                    words_done++;
                end else begin
                    mon_bits++;
                end
            end
            since_rise++;
            if (out_wr) begin
                if (exp_out_q.size() == 0) check("out_wr_unexpected", 1, 0);
                else check("out_data", out_data, exp_out_q.pop_front());
            end
            prev_tck = tck;
        end
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((fifo_q.size() != 0 || busy || pend || exp_tdi_q.size() != 0 ||
                exp_out_q.size() != 0) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_timeout"}, n < 5000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int r0, k0, n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tck", tck, 0); check("rst_tdi", tdi, 0); check("rst_busy", busy, 0);
        check("rst_in_rd", in_rd, 0); check("rst_out_wr", out_wr, 0); check("rst_out_data", out_data, 0);
        @(posedge clk); #2 rst = 1'b0;

        // single word 0xA5
        r0 = rd_cnt; k0 = rise_cnt;
        push(8'hA5, DW'($urandom));
        en = 1'b1;
        wait_idle("a5");
        check("a5_pops", rd_cnt - r0, 1);
        check("a5_rises", rise_cnt - k0, DW);

        // loopback 0x3C
        push(8'h3C, '0);
        wait_idle("loop");

        // two queued words back to back
        en = 1'b0;
        r0 = rd_cnt; k0 = rise_cnt;
        push(8'h01, DW'($urandom));
        push(8'h80, DW'($urandom));
        @(posedge clk); #1 en = 1'b1;
        wait_idle("pair");
        check("pair_pops", rd_cnt - r0, 2);
        check("pair_rises", rise_cnt - k0, 2 * DW);

        // downstream backpressure held in STORE
        out_full = 1'b1;
        k0 = words_done;
        push(DW'($urandom), DW'($urandom));
        push(DW'($urandom), DW'($urandom));
`ifdef JTAG_SHIFTER_CAPTURE_EN
        n = 0;
        while (words_done == k0 && n < 500) begin @(posedge clk); #1; n++; end
        check("bp_reach_timeout", n < 500, 1'b1);
        repeat (20) begin
            check("bp_tck", tck, 0); check("bp_in_rd", in_rd, 0);
            check("bp_out_wr", out_wr, 0); check("bp_busy", busy, 1);
            @(posedge clk); #1;
        end
        out_full = 1'b0;
        #1 check("bp_release_wr", out_wr, 1);
        @(posedge clk); #1;
        check("bp_next_pop", in_rd, 1);
`endif
        out_full = 1'b0;
        wait_idle("bp");

        // reset three bits into a word
        push(DW'($urandom), DW'($urandom));
        n = 0;
        while (mon_bits != 3 && n < 500) begin @(posedge clk); #1; n++; end
        check("mid_reach_timeout", n < 500, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_tck", tck, 0); check("mid_rst_tdi", tdi, 0); check("mid_rst_busy", busy, 0);
        if (exp_tdi_q.size() != 0) void'(exp_tdi_q.pop_back());
        if (exp_out_q.size() != 0) void'(exp_out_q.pop_back());
        @(posedge clk); #2 rst = 1'b0;
        push(8'h5A, DW'($urandom));
        wait_idle("restart");

        // nothing to do: empty fifo, then data without enable
        repeat (10) begin
            check("empty_rd", in_rd, 0); check("empty_busy", busy, 0);
            @(posedge clk); #1;
        end
        en = 1'b0;
        push(DW'($urandom), DW'($urandom));
        repeat (10) begin
            check("noen_rd", in_rd, 0); check("noen_busy", busy, 0); check("noen_tck", tck, 0);
            @(posedge clk); #1;
        end
        en = 1'b1;
        wait_idle("noen");

        // randomized traffic with enable and backpressure toggling
        repeat (30) push(DW'($urandom), DW'($urandom));
        repeat (600) begin
            en = ($urandom_range(0, 3) != 0);
            out_full = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        en = 1'b1;
        out_full = 1'b0;
        wait_idle("rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end
endmodule
